// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32IM execute-stage functional unit.
//
// Accepts one request per handshake (base ALU op selected by alu_ctrl, or an
// M-extension op selected by md_op when md_en is set) and returns a
// registered 32-bit result over a valid/ready handshake.
//   - Base ops, illegal codes and divide early-outs (divide by zero, signed
//     overflow) complete with latency 1.
//   - Divide/remainder iterate 32 times (radix-2 restoring, on magnitudes),
//     latency 33.
//   - Multiply iterates 32 times (radix-2 shift-add, on magnitudes), latency
//     33, unless the macro FAST_MUL_EN is defined, in which case a single-cycle
//     33x33 signed multiplier is used (latency 1). Results are identical.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   in_valid   request present
//   in_ready   unit can accept a request this cycle
//   alu_ctrl   base op code (0000 AND .. 1001 SRA; other codes are illegal)
//   md_en      request is an M-extension op (alu_ctrl ignored)
//   md_op      M-extension funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   operand_a  rs1
//   operand_b  rs2 / immediate
//   out_valid  result is valid (held until consumed)
//   out_ready  consumer takes the result
//   result     registered result
//   zero       result == 0, registered with result
//   illegal    request carried an illegal alu_ctrl (result forced to 0)
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic            md_en,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } state_t;

  localparam logic [5:0]      LAST_ITER = 6'd31;
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

  // Base ALU; returns {illegal, result}.
  function automatic logic [XLEN:0] alu_base(input logic [3:0]      ctrl,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [4:0]             sh;
    logic [XLEN-1:0]        r;
    logic                   ill;
    sa  = a;
    sb  = b;
    sh  = b[4:0];
    r   = '0;
    ill = 1'b0;
    case (ctrl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a - b;
      4'b0100: r = a << sh;
      4'b0101: r = {{(XLEN-1){1'b0}}, (sa < sb)};
      4'b0110: r = {{(XLEN-1){1'b0}}, (a < b)};
      4'b0111: r = a ^ b;
      4'b1000: r = a >> sh;
      4'b1001: r = sa >>> sh;
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
    return {ill, r};
  endfunction

  // One shift-add step: acc = {partial_hi, multiplier_remaining}.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   d);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, d} : {(XLEN+1){1'b0}});
    return {sum, acc[XLEN-1:1]};
  endfunction

  // One restoring-division step: acc = {remainder, dividend/quotient}.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   d);
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] nr;
    rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge     = (rem_sh >= {1'b0, d});
    nr     = ge ? (rem_sh[XLEN-1:0] - d) : rem_sh[XLEN-1:0];
    return {nr, acc[XLEN-2:0], ge};
  endfunction

  // Sign fix-up of the magnitude product and half selection (op 00 = MUL).
  function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] acc,
                                              input logic              neg,
                                              input logic [1:0]        op);
    logic [2*XLEN-1:0] p;
    p = neg ? -acc : acc;
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Sign fix-up of quotient or remainder.
  function automatic logic [XLEN-1:0] div_fix(input logic [2*XLEN-1:0] acc,
                                              input logic              neg,
                                              input logic              is_rem);
    logic [XLEN-1:0] v;
    v = is_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    return neg ? -v : v;
  endfunction

  // Divide-by-zero and signed-overflow results.
  function automatic logic [XLEN-1:0] div_early_res(input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b,
                                                    input logic            is_rem);
    if (b == '0) return is_rem ? a : ALL_ONES;
    return is_rem ? {XLEN{1'b0}} : INT_MIN;
  endfunction

`ifdef FAST_MUL_EN
  // Single-cycle multiply: operands extended to 33 bits by their signedness,
  // then multiplied as 64-bit two's complement (low 64 bits are exact).
  function automatic logic [XLEN-1:0] mul_fast(input logic [2:0]      op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN:0]     ea;
    logic [XLEN:0]     eb;
    logic [2*XLEN-1:0] p;
    ea = {(op != 3'b011) & a[XLEN-1], a};
    eb = {(op[1] == 1'b0) & b[XLEN-1], b};
    p  = {{(XLEN-1){ea[XLEN]}}, ea} * {{(XLEN-1){eb[XLEN]}}, eb};
    return (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction
`endif

  state_t            state, state_nxt;
  logic [5:0]        cnt;
  logic              accept;
  logic              load_out;
  logic              start_mul;
  logic              start_div;
  logic [XLEN-1:0]   res_nxt;
  logic              ill_nxt;

  logic              sgn_a, sgn_b;
  logic              a_neg, b_neg;
  logic              neg_nxt;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_early;

  logic [2*XLEN-1:0] acc_p1;
  logic [XLEN-1:0]   opnd_p1;
  logic              neg_p1;
  logic [1:0]        op_p1;
  logic [2*XLEN-1:0] acc_step;

  // ---- stage p0: operand preparation for M ops ----
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    if (md_op[2]) begin
      sgn_a = ~md_op[0];
      sgn_b = ~md_op[0];
    end else begin
      sgn_a = (md_op != 3'b011);
      sgn_b = ~md_op[1];
    end
    a_neg     = sgn_a & operand_a[XLEN-1];
    b_neg     = sgn_b & operand_b[XLEN-1];
    mag_a     = a_neg ? -operand_a : operand_a;
    mag_b     = b_neg ? -operand_b : operand_b;
    // Remainder takes the sign of the dividend; everything else is a XOR b.
    neg_nxt   = (md_op[2] & md_op[1]) ? a_neg : (a_neg ^ b_neg);
    div_early = (operand_b == '0) ||
                (~md_op[0] && (operand_a == INT_MIN) && (operand_b == ALL_ONES));
  end

  assign acc_step = (state == DIV_BUSY) ? div_step(acc_p1, opnd_p1)
                                        : mul_step(acc_p1, opnd_p1);

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_mul)      state_nxt = MUL_BUSY;
        else if (start_div) state_nxt = DIV_BUSY;
      end
      MUL_BUSY, DIV_BUSY: if (cnt == LAST_ITER) state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. in_ready depends only on registered state and out_ready.
  always_comb begin
    in_ready  = (state == IDLE) && (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    load_out  = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    res_nxt   = '0;
    ill_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!md_en) begin
            {ill_nxt, res_nxt} = alu_base(alu_ctrl, operand_a, operand_b);
            load_out           = 1'b1;
          end else if (!md_op[2]) begin
`ifdef FAST_MUL_EN
            res_nxt  = mul_fast(md_op, operand_a, operand_b);
            load_out = 1'b1;
`else
            start_mul = 1'b1;
`endif
          end else if (div_early) begin
            res_nxt  = div_early_res(operand_a, operand_b, md_op[1]);
            load_out = 1'b1;
          end else begin
            start_div = 1'b1;
          end
        end
      end
      // The final iteration's step result is fixed up and loaded directly.
      MUL_BUSY: begin
        if (cnt == LAST_ITER) begin
          res_nxt  = mul_fix(acc_step, neg_p1, op_p1);
          load_out = 1'b1;
        end
      end
      DIV_BUSY: begin
        if (cnt == LAST_ITER) begin
          res_nxt  = div_fix(acc_step, neg_p1, op_p1[1]);
          load_out = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---- stage p1: iteration counter and output register ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (start_mul || start_div) cnt <= '0;
      else if (state != IDLE)     cnt <= cnt + 6'd1;

      if (load_out) begin
        out_valid <= 1'b1;
        result    <= res_nxt;
        zero      <= (res_nxt == '0);
        illegal   <= ill_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // ---- stage p1: iterative datapath (multiplier low half holds the
  // remaining multiplier bits; divider low half holds dividend/quotient) ----
  always_ff @(posedge clk) begin
    if (start_mul || start_div) begin
      acc_p1  <= {{XLEN{1'b0}}, (md_op[2] ? mag_a : mag_b)};
      opnd_p1 <= md_op[2] ? mag_b : mag_a;
      neg_p1  <= neg_nxt;
      op_p1   <= md_op[1:0];
    end else if (state != IDLE) begin
      acc_p1  <= acc_step;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: scenario tasks drive requests and push the
// expected result into a scoreboard; a monitor pops and compares whenever a
// result is consumed. Latency, stall and reset behaviour are checked inline.
module tb_alu_exec_unit;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl  = 4'd0;
  logic        md_en     = 1'b0;
  logic [2:0]  md_op     = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];   // {result, illegal}
  string       name_q[$];
  logic [32:0] mon_e;
  string       mon_n;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .md_en(md_en), .md_op(md_op),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: a result is consumed at the posedge following a
  // negedge where out_valid && out_ready.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got result=%h with nothing expected", result);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (result !== mon_e[32:1] || zero !== (mon_e[32:1] == 32'd0) || illegal !== mon_e[0]) begin
          n_fail++;
          $display("FAIL %s: got result=%h zero=%b illegal=%b, expected result=%h zero=%b illegal=%b",
                   mon_n, result, zero, illegal, mon_e[32:1], (mon_e[32:1] == 32'd0), mon_e[0]);
        end
      end
    end
  end

  // Drive one request until accepted; push its expected result.
  task automatic send(input string nm, input logic md, input logic [3:0] ctrl,
                      input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ei);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    md_en     = md;
    alu_ctrl  = ctrl;
    md_op     = op;
    operand_a = a;
    operand_b = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: in_ready stuck at %b, required 1", nm, in_ready);
    end else begin
      exp_q.push_back({er, ei});
      name_q.push_back(nm);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge: counts further edges until out_valid,
  // and reports whether in_ready was seen high meanwhile.
  task automatic wait_out(output int cyc, output bit rdy_seen);
    cyc      = 0;
    rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h, required 0", result); end
    n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b, required 0", zero); end
    n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b, required 0", illegal); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_base();
    int cyc; bit rdy;
    send("add_wrap", 0, 4'b0010, 3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
    wait_out(cyc, rdy);
    n_tests++; if (cyc + 1 !== 1) begin n_fail++; $display("FAIL add_latency: got %0d, required 1", cyc + 1); end
    send("sub_zero",  0, 4'b0011, 3'd0, 32'd5,        32'd5,        32'd0,        0);
    send("sra_31",    0, 4'b1001, 3'd0, 32'h8000_0000, 32'd31,      32'hFFFF_FFFF, 0);
    send("srl_31",    0, 4'b1000, 3'd0, 32'h8000_0000, 32'd31,      32'h1,        0);
    send("sltu",      0, 4'b0110, 3'd0, 32'h1,        32'hFFFF_FFFF, 32'h1,       0);
    send("slt",       0, 4'b0101, 3'd0, 32'h1,        32'hFFFF_FFFF, 32'h0,       0);
    send("xor",       0, 4'b0111, 3'd0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 0);
    send("and",       0, 4'b0000, 3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0);
    send("or",        0, 4'b0001, 3'd0, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 0);
    send("sll_mask",  0, 4'b0100, 3'd0, 32'h1,        32'h23,       32'h8,        0);
    send("sra_pos",   0, 4'b1001, 3'd0, 32'h4000_0000, 32'd4,       32'h0400_0000, 0);
  endtask

  task automatic test_div();
    int cyc; bit rdy;
    send("div_m7_2", 1, 4'd0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    wait_out(cyc, rdy);
    n_tests++; if (cyc + 1 !== 33) begin n_fail++; $display("FAIL div_latency: got %0d, required 33", cyc + 1); end
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL div_in_ready_busy: got high, required low"); end
    send("rem_m7_2", 1, 4'd0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    wait_out(cyc, rdy);
    n_tests++; if (cyc + 1 !== 33) begin n_fail++; $display("FAIL rem_latency: got %0d, required 33", cyc + 1); end
    send("divu_by0", 1, 4'd0, 3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);
    wait_out(cyc, rdy);
    n_tests++; if (cyc + 1 !== 1) begin n_fail++; $display("FAIL divu_by0_latency: got %0d, required 1", cyc + 1); end
    send("div_ovf", 1, 4'd0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    wait_out(cyc, rdy);
    n_tests++; if (cyc + 1 !== 1) begin n_fail++; $display("FAIL div_ovf_latency: got %0d, required 1", cyc + 1); end
    send("remu_by0",  1, 4'd0, 3'b111, 32'd7,         32'd0,         32'd7,         0);
    send("rem_ovf",   1, 4'd0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
    send("divu_100_7",1, 4'd0, 3'b101, 32'd100,       32'd7,         32'd14,        0);
    send("remu_100_7",1, 4'd0, 3'b111, 32'd100,       32'd7,         32'd2,         0);
    send("div_100_m7",1, 4'd0, 3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 0);
    send("rem_m100_7",1, 4'd0, 3'b110, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 0);
    send("divu_big",  1, 4'd0, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
  endtask

  task automatic test_mul();
    int cyc; bit rdy;
    send("mulh_min", 1, 4'd0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    wait_out(cyc, rdy);
    n_tests++; if (cyc + 1 !== MUL_LAT) begin n_fail++; $display("FAIL mul_latency: got %0d, required %0d", cyc + 1, MUL_LAT); end
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready_busy: got high, required low"); end
    send("mulhu_max",  1, 4'd0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    send("mulhsu",     1, 4'd0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    send("mul_neg",    1, 4'd0, 3'b000, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFF1, 0);
    send("mul_shift",  1, 4'd0, 3'b000, 32'h1234_5678, 32'h10,        32'h2345_6780, 0);
    send("mulh_small", 1, 4'd0, 3'b001, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 0);
    send("mulhu_mid",  1, 4'd0, 3'b011, 32'h8000_0000, 32'd4,         32'h0000_0002, 0);
  endtask

  task automatic test_stall();
    bit bad;
    drain();
    out_ready = 1'b0;
    send("stall_add", 0, 4'b0010, 3'd0, 32'd2, 32'd3, 32'd5, 0);
    in_valid  = 1'b1;
    md_en     = 1'b0;
    alu_ctrl  = 4'b0111;
    operand_a = 32'h0000_00F0;
    operand_b = 32'h0000_000F;
    exp_q.push_back({32'h0000_00FF, 1'b0});
    name_q.push_back("stall_xor");
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (result !== 32'd5 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL stall_hold: result=%h out_valid=%b in_ready=%b, required 00000005/1/0", result, out_valid, in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (result !== 32'h0000_00FF || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_same_edge: got %h/%b, required 000000ff/1", result, out_valid); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    drain();
    send("abort_divu", 1, 4'd0, 3'b101, 32'd1000, 32'd3, 32'd333, 0);
    repeat (9) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b, required 0", out_valid); end
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL abort_result: got %h, required 0", result); end
    exp_q.delete();
    name_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL abort_no_result: got out_valid high, required low"); end
    @(posedge clk); #1;
    send("illegal_1111", 0, 4'b1111, 3'd0, 32'd123, 32'd456, 32'd0, 1);
    send("illegal_1010", 0, 4'b1010, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    send("legal_after",  0, 4'b0010, 3'd0, 32'd1, 32'd2, 32'd3, 0);
  endtask

  initial begin
    test_reset();
    test_base();
    test_div();
    test_mul();
    test_stall();
    test_reset_abort();
    drain();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results never produced, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
